// File: rtl/micro_tile_switch.sv
// micro_tile_switch: sequenced tile-selection controller for the micro-tile container.
// Synchronises the asynchronous select pins and walks every tile change through
// drain-reset, a one-cycle clock-off gap and wake-reset, so no tile ever sees a runt
// clock or an input swap mid-cycle. Clock enables, resets and uo_out are registered.
module micro_tile_switch #(
  parameter int unsigned N_TILES     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_HOLD    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic [7:0]             ui_in,
  input  logic [8*N_TILES-1:0]   tile_uo,
  output logic [8*N_TILES-1:0]   tile_ui,
  output logic [N_TILES-1:0]     tile_clk_en,
  output logic [N_TILES-1:0]     tile_rst_n,
  output logic [7:0]             uo_out,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   busy
);

  localparam int unsigned StartW = $clog2(SYNC_STAGES + 1);
  localparam int unsigned HoldW  = $clog2(RST_HOLD + 1);

  localparam logic [StartW-1:0] StartMax = StartW'(SYNC_STAGES);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(RST_HOLD - 1);
  localparam logic [SEL_W:0]    NumTiles = (SEL_W + 1)'(N_TILES);

  typedef enum logic [2:0] {
    StPark,
    StWake,
    StActive,
    StDrain,
    StSwitch
  } state_e;

  // Synchroniser chain for the asynchronous select pins.
  logic [SEL_W-1:0] r_sync [SYNC_STAGES];

  // FSM and registered output state.
  state_e             r_state;
  logic [SEL_W-1:0]   r_cur_sel;
  logic [HoldW-1:0]   r_hold;
  logic [StartW-1:0]  r_start;
  logic [N_TILES-1:0] r_clk_en;
  logic [N_TILES-1:0] r_tile_rst_n;
  logic [7:0]         r_uo;
  logic               r_busy;

  // Next-state and decode wires.
  logic [SEL_W-1:0]   w_sel_sync;
  logic               w_sel_valid;
  state_e             w_state_d;
  logic [SEL_W-1:0]   w_cur_d;
  logic [HoldW-1:0]   w_hold_d;
  logic [StartW-1:0]  w_start_d;
  logic [N_TILES-1:0] w_cur_oh;
  logic [N_TILES-1:0] w_next_oh;
  logic [7:0]         w_uo_sel;
  logic               w_route;
  logic               w_next_clk_on;

  assign w_sel_sync  = r_sync[SYNC_STAGES-1];
  assign w_sel_valid = ({1'b0, w_sel_sync} < NumTiles);

  // Shift sel_in through SYNC_STAGES flops before anything looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= sel_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Next-state logic; r_hold times both the drain and wake reset windows.
  always_comb begin
    w_state_d = r_state;
    w_cur_d   = r_cur_sel;
    w_hold_d  = r_hold;
    w_start_d = r_start;
    unique case (r_state)
      StPark: begin
        // The startup counter keeps the reset-value sel_sync from being trusted
        // before a real pin sample has made it through the synchroniser.
        if (r_start != StartMax) begin
          w_start_d = r_start + 1'b1;
        end else if (w_sel_valid) begin
          w_state_d = StWake;
          w_cur_d   = w_sel_sync;
          w_hold_d  = '0;
        end
      end
      StWake: begin
        if (r_hold == HoldLast) begin
          w_state_d = StActive;
        end else begin
          w_hold_d = r_hold + 1'b1;
        end
      end
      StActive: begin
        if (w_sel_sync != r_cur_sel) begin
          w_state_d = StDrain;
          w_hold_d  = '0;
        end
      end
      StDrain: begin
        if (r_hold == HoldLast) begin
          w_state_d = StSwitch;
        end else begin
          w_hold_d = r_hold + 1'b1;
        end
      end
      StSwitch: begin
        // Re-sample here: a same-index request still gets a full re-reset.
        if (w_sel_valid) begin
          w_state_d = StWake;
          w_cur_d   = w_sel_sync;
          w_hold_d  = '0;
        end else begin
          w_state_d = StPark;
        end
      end
      default: w_state_d = StPark;
    endcase
  end

  // One-hot decode of the current and next owned tile.
  always_comb begin
    w_cur_oh  = '0;
    w_next_oh = '0;
    for (int unsigned k = 0; k < N_TILES; k++) begin
      w_cur_oh[k]  = (r_cur_sel == SEL_W'(k));
      w_next_oh[k] = (w_cur_d == SEL_W'(k));
    end
  end

  // Output mux from the currently owned tile.
  always_comb begin
    w_uo_sel = '0;
    for (int unsigned k = 0; k < N_TILES; k++) begin
      if (w_cur_oh[k]) begin
        w_uo_sel = tile_uo[8*k +: 8];
      end
    end
  end

  assign w_route = (r_state == StWake) || (r_state == StActive) || (r_state == StDrain);
  assign w_next_clk_on = (w_state_d == StWake) || (w_state_d == StActive) ||
                         (w_state_d == StDrain);

  // Input fan-out: only the owned tile sees ui_in, and only while it is clocked.
  always_comb begin
    tile_ui = '0;
    if (w_route) begin
      for (int unsigned k = 0; k < N_TILES; k++) begin
        if (w_cur_oh[k]) begin
          tile_ui[8*k +: 8] = ui_in;
        end
      end
    end
  end

  // FSM state plus outputs registered from the next state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StPark;
      r_cur_sel    <= '0;
      r_hold       <= '0;
      r_start      <= '0;
      r_clk_en     <= '0;
      r_tile_rst_n <= '0;
      r_uo         <= '0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_cur_sel    <= w_cur_d;
      r_hold       <= w_hold_d;
      r_start      <= w_start_d;
      r_clk_en     <= w_next_clk_on ? w_next_oh : '0;
      r_tile_rst_n <= (w_state_d == StActive) ? w_next_oh : '0;
      r_busy       <= (w_state_d != StActive);
      r_uo         <= (r_state == StActive) ? w_uo_sel : 8'h00;
    end
  end

  assign tile_clk_en = r_clk_en;
  assign tile_rst_n  = r_tile_rst_n;
  assign uo_out      = r_uo;
  assign cur_sel     = r_cur_sel;
  assign busy        = r_busy;

endmodule

// File: tb/tb_micro_tile_switch.sv
// Self-checking bench for micro_tile_switch (N_TILES=4, SEL_W=3 so an out-of-range
// select can be driven). Table of tile switches with a scoreboard queue, plus
// hand-written sequences for startup, glitch, invalid select, mid-WAKE request and
// reset asserted mid-DRAIN.
module tb_micro_tile_switch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel_in;
  logic [7:0]  ui_in;
  logic [31:0] tile_uo;
  logic [31:0] tile_ui;
  logic [3:0]  tile_clk_en;
  logic [3:0]  tile_rst_n;
  logic [7:0]  uo_out;
  logic [2:0]  cur_sel;
  logic        busy;

  always #5 clk = ~clk;

  micro_tile_switch #(
    .N_TILES    (4),
    .SEL_W      (3),
    .SYNC_STAGES(2),
    .RST_HOLD   (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_in     (sel_in),
    .ui_in      (ui_in),
    .tile_uo    (tile_uo),
    .tile_ui    (tile_ui),
    .tile_clk_en(tile_clk_en),
    .tile_rst_n (tile_rst_n),
    .uo_out     (uo_out),
    .cur_sel    (cur_sel),
    .busy       (busy)
  );

  typedef struct {
    logic [2:0] sel;
    logic [7:0] uo;
    logic [7:0] ui;
    int         edges;
  } vec_t;

  vec_t       vecs[3];
  vec_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] tb_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one clock enable may be high at any time.
  always @(negedge clk) begin
    check("onehot_clk_en", 32'($countones(tile_clk_en) <= 1), 32'd1);
  end

  // rst_n is low on entry; releases it and checks the startup timeline edge by edge.
  task automatic reset_start(input logic [2:0] sel, input logic [7:0] uo);
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    sel_in = sel;
    ui_in  = 8'h5C;
    tick();
    check("rst_clk_en", tile_clk_en, 0);
    check("rst_tile_rst_n", tile_rst_n, 0);
    check("rst_uo_out", uo_out, 0);
    check("rst_busy", busy, 1);
    check("rst_cur_sel", cur_sel, 0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 2) begin
        check("start_e2_clk_en", tile_clk_en, 0);
        check("start_e2_tile_ui", tile_ui, 0);
      end
      if (e == 3) begin
        check("start_e3_clk_en", tile_clk_en, oh);
        check("start_e3_tile_rst_n", tile_rst_n, 0);
        check("start_e3_tile_ui", tile_ui, 32'(ui_in) << (8 * sel));
      end
      if (e == 6) check("start_e6_busy", busy, 1);
      if (e == 7) begin
        check("start_e7_tile_rst_n", tile_rst_n, oh);
        check("start_e7_busy", busy, 0);
        check("start_e7_uo_out", uo_out, 0);
      end
      if (e == 8) check("start_e8_uo_out", uo_out, uo);
    end
    tb_cur = sel;
  endtask

  // Drives one select change from an ACTIVE tile and scoreboards the result.
  task automatic do_switch(input vec_t v);
    logic [3:0] old_oh;
    logic [3:0] new_oh;
    int         idx;
    int         drain;
    int         gap;
    int         wake;
    bit         done;
    bit         saw_busy;
    vec_t       e;
    old_oh   = 4'b0001 << tb_cur;
    new_oh   = 4'b0001 << v.sel;
    idx      = -1;
    drain    = 0;
    gap      = 0;
    wake     = 0;
    done     = 1'b0;
    saw_busy = 1'b0;
    sel_in   = v.sel;
    ui_in    = v.ui;
    sb.push_back(v);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (tile_clk_en == old_oh && tile_rst_n == 4'b0) drain++;
      if (tile_clk_en == 4'b0) gap++;
      if (tile_clk_en == new_oh && tile_rst_n == 4'b0) wake++;
      if (busy) saw_busy = 1'b1;
      if (saw_busy && !busy) begin
        done = 1'b1;
        idx  = i;
      end
    end
    check("switch_completed", done, 1);
    e = sb.pop_front();
    check("switch_edges", idx, e.edges);
    check("switch_cur_sel", cur_sel, e.sel);
    check("switch_clk_en", tile_clk_en, new_oh);
    check("switch_tile_rst_n", tile_rst_n, new_oh);
    check("switch_drain_cycles", drain, 4);
    check("switch_gap_cycles", gap, 1);
    check("switch_wake_cycles", wake, 4);
    check("switch_tile_ui", tile_ui, 32'(e.ui) << (8 * e.sel));
    tick();
    check("switch_uo_out", uo_out, e.uo);
    tb_cur = v.sel;
  endtask

  initial begin
    int hi;
    vecs[0] = '{sel: 3'd1, uo: 8'h5A, ui: 8'h11, edges: 11};
    vecs[1] = '{sel: 3'd3, uo: 8'hC3, ui: 8'h22, edges: 11};
    vecs[2] = '{sel: 3'd0, uo: 8'h3C, ui: 8'h33, edges: 11};

    rst_n   = 1'b0;
    sel_in  = 3'd0;
    ui_in   = 8'h00;
    tile_uo = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
    tb_cur  = 3'd0;
    tick();
    tick();

    // Startup on tile 2.
    reset_start(3'd2, 8'hA5);

    // Table of switches: 2->1, 1->3, 3->0.
    for (int i = 0; i < 3; i++) begin
      do_switch(vecs[i]);
    end

    // Glitch shorter than a clock period never reaches sel_sync.
    sel_in = 3'd2;
    #3;
    sel_in = 3'd0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) hi++;
    end
    check("glitch_busy_cycles", hi, 0);
    check("glitch_cur_sel", cur_sel, 0);

    // Out-of-range select: drain tile 0, then park.
    sel_in = 3'd5;
    for (int i = 0; i <= 11; i++) begin
      tick();
      if (i == 2) begin
        check("inval_drain_clk_en", tile_clk_en, 4'b0001);
        check("inval_drain_rst_n", tile_rst_n, 0);
      end
      if (i == 6) check("inval_switch_clk_en", tile_clk_en, 0);
    end
    check("park_busy", busy, 1);
    check("park_clk_en", tile_clk_en, 0);
    check("park_tile_rst_n", tile_rst_n, 0);
    check("park_uo_out", uo_out, 0);
    check("park_tile_ui", tile_ui, 0);

    // Valid select from PARK: WAKE on the edge after sel_sync becomes 0.
    sel_in = 3'd0;
    tick();
    check("unpark_e0_clk_en", tile_clk_en, 0);
    tick();
    check("unpark_e1_clk_en", tile_clk_en, 0);
    tick();
    check("unpark_e2_clk_en", tile_clk_en, 4'b0001);
    check("unpark_e2_rst_n", tile_rst_n, 0);

    // Request tile 1 while tile 0 is still in WAKE.
    sel_in = 3'd1;
    tick();
    tick();
    tick();
    check("wake_w3_clk_en", tile_clk_en, 4'b0001);
    check("wake_w3_rst_n", tile_rst_n, 0);
    tick();
    check("wake_w4_rst_n", tile_rst_n, 4'b0001);
    check("wake_w4_busy", busy, 0);
    tick();
    check("wake_w5_busy", busy, 1);
    check("wake_w5_rst_n", tile_rst_n, 0);
    check("wake_w5_clk_en", tile_clk_en, 4'b0001);
    check("wake_w5_uo_out", uo_out, 8'h3C);
    tick();
    tick();
    tick();
    tick();
    check("wake_w9_clk_en", tile_clk_en, 0);
    tick();
    check("wake_w10_clk_en", tile_clk_en, 4'b0010);
    check("wake_w10_rst_n", tile_rst_n, 0);
    tick();
    tick();
    tick();
    tick();
    check("wake_w14_busy", busy, 0);
    check("wake_w14_cur_sel", cur_sel, 1);
    check("wake_w14_rst_n", tile_rst_n, 4'b0010);
    tick();
    check("wake_w15_uo_out", uo_out, 8'h5A);
    tb_cur = 3'd1;

    // Reset asserted mid-DRAIN of tile 1.
    sel_in = 3'd2;
    for (int i = 0; i < 4; i++) tick();
    check("middrain_clk_en", tile_clk_en, 4'b0010);
    check("middrain_rst_n", tile_rst_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clk_en", tile_clk_en, 0);
    check("async_tile_rst_n", tile_rst_n, 0);
    check("async_uo_out", uo_out, 0);
    check("async_busy", busy, 1);
    check("async_cur_sel", cur_sel, 0);
    check("async_tile_ui", tile_ui, 0);
    reset_start(3'd2, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
